xor_te_seq: RTL and testbench

- Sequential tritwise XOR engine over an N-trit word (default one 9-trit tryte).
- Shares a single xor_te cell across all trit positions. One trit is processed per clock, LSB trit first.
- A start/busy/done handshake allows a control unit to launch a word operation and collect the result.
- Reports the first malformed trit (code 2'b11) with its position.

---
 rtl/ternary_pkg.sv | 18 +
 rtl/xor_te.sv | 29 ++
 rtl/xor_te_seq.sv | 121 ++++++++++++
 tb/tb_xor_te_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared balanced-ternary definitions: trit codes, trit width and the
// state encoding used by the sequential trit engines.
package ternary_pkg;

    localparam int TRIT_W = 2;

    localparam logic [TRIT_W-1:0] TRIT_POS  = 2'b10;
    localparam logic [TRIT_W-1:0] TRIT_ZERO = 2'b00;
    localparam logic [TRIT_W-1:0] TRIT_NEG  = 2'b01;
    localparam logic [TRIT_W-1:0] TRIT_ERR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/xor_te.sv
// Combinational tritwise XOR cell: balanced sum of two trits modulo 3.
// A malformed input trit forces a zero result and raises err.
module xor_te
    import ternary_pkg::*;
(
    input  logic [TRIT_W-1:0] a,
    input  logic [TRIT_W-1:0] b,
    output logic [TRIT_W-1:0] c,
    output logic              err
);

    always_comb begin
        c   = TRIT_ZERO;
        err = 1'b0;
        if (a == TRIT_ERR || b == TRIT_ERR) begin
            err = 1'b1;
        end else if (a == TRIT_ZERO) begin
            c = b;
        end else if (b == TRIT_ZERO) begin
            c = a;
        end else if (a == b) begin
            // +1 + +1 wraps to -1, -1 + -1 wraps to +1
            c = (a == TRIT_POS) ? TRIT_NEG : TRIT_POS;
        end else begin
            c = TRIT_ZERO;
        end
    end

endmodule

// File: rtl/xor_te_seq.sv
// Sequential tritwise XOR over an N-trit word using one shared xor_te cell,
// one trit per clock LSB first, with start/busy/done handshake and error capture.
module xor_te_seq
    import ternary_pkg::*;
#(
    parameter int N_TRITS     = 9,
    parameter bit STOP_ON_ERR = 1'b0,
    parameter int IDX_W       = $clog2(N_TRITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [TRIT_W*N_TRITS-1:0] a,
    input  logic [TRIT_W*N_TRITS-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [TRIT_W*N_TRITS-1:0] c,
    output logic                      err,
    output logic [IDX_W-1:0]          err_idx
);

    localparam int              WORD_W   = TRIT_W * N_TRITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TRITS - 1);

    // Handshake: start is sampled only in IDLE; busy covers RUN and DONE;
    // done is a single-cycle pulse in DONE when c/err/err_idx are valid.
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  a_q, b_q, c_q;
    logic               err_q;
    logic [IDX_W-1:0]   err_idx_q;
    logic               accept;

    logic [TRIT_W-1:0]  sel_a, sel_b, cell_c;
    logic               cell_err;

    always_comb begin
        sel_a = TRIT_ZERO;
        sel_b = TRIT_ZERO;
        for (int i = 0; i < N_TRITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_a = a_q[i*TRIT_W +: TRIT_W];
                sel_b = b_q[i*TRIT_W +: TRIT_W];
            end
        end
    end

    xor_te u_cell (
        .a   (sel_a),
        .b   (sel_b),
        .c   (cell_c),
        .err (cell_err)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (idx_q == LAST_IDX || (STOP_ON_ERR && cell_err)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (accept) begin
            idx_q     <= '0;
            a_q       <= a;
            b_q       <= b;
            c_q       <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (state_q == S_RUN) begin
            for (int i = 0; i < N_TRITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    c_q[i*TRIT_W +: TRIT_W] <= cell_c;
                end
            end
            if (cell_err && !err_q) begin
                err_q     <= 1'b1;
                err_idx_q <= idx_q;
            end
            // On an early abort the index freezes; untouched trits stay zero.
            if (state_d == S_RUN) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign c       = c_q;
    assign err     = err_q;
    assign err_idx = err_idx_q;

endmodule

// File: tb/tb_xor_te_seq.sv
// Bench for xor_te_seq: three instances (N=3 full scan, N=3 abort, N=9 full scan)
// driven with directed and random words against an arithmetic reference model.
module tb_xor_te_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_v[3];
    logic [17:0] a_v[3];
    logic [17:0] b_v[3];
    logic        busy_v[3];
    logic        done_v[3];
    logic        err_v[3];
    logic [17:0] c_v[3];
    logic [3:0]  idx_v[3];

    int nt[3]  = '{3, 3, 9};
    bit stp[3] = '{1'b0, 1'b1, 1'b0};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic [5:0]  c0, c1;
    logic [17:0] c2;
    logic [1:0]  i0, i1;
    logic [3:0]  i2;
    logic        bu0, bu1, bu2, dn0, dn1, dn2, er0, er1, er2;

    xor_te_seq #(.N_TRITS(3), .STOP_ON_ERR(1'b0)) dut_n (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][5:0]), .b(b_v[0][5:0]),
        .busy(bu0), .done(dn0), .c(c0), .err(er0), .err_idx(i0)
    );

    xor_te_seq #(.N_TRITS(3), .STOP_ON_ERR(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][5:0]), .b(b_v[1][5:0]),
        .busy(bu1), .done(dn1), .c(c1), .err(er1), .err_idx(i1)
    );

    xor_te_seq #(.N_TRITS(9), .STOP_ON_ERR(1'b0)) dut_f (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .busy(bu2), .done(dn2), .c(c2), .err(er2), .err_idx(i2)
    );

    assign busy_v[0] = bu0;
    assign busy_v[1] = bu1;
    assign busy_v[2] = bu2;
    assign done_v[0] = dn0;
    assign done_v[1] = dn1;
    assign done_v[2] = dn2;
    assign err_v[0]  = er0;
    assign err_v[1]  = er1;
    assign err_v[2]  = er2;
    assign c_v[0]    = {12'b0, c0};
    assign c_v[1]    = {12'b0, c1};
    assign c_v[2]    = c2;
    assign idx_v[0]  = {2'b0, i0};
    assign idx_v[1]  = {2'b0, i1};
    assign idx_v[2]  = i2;

    // ---------------- reference model ----------------
    function automatic int tval(input logic [1:0] t);
        if (t == 2'b10) return 1;
        if (t == 2'b01) return -1;
        return 0;
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v == 1)  return 2'b10;
        if (v == -1) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model(input int n, input bit stop, input logic [17:0] av, input logic [17:0] bv,
                         output logic [17:0] ce, output logic ee, output logic [3:0] ie, output int le);
        logic [1:0] ta, tb;
        int s;
        ce = '0; ee = 1'b0; ie = '0; le = n + 1;
        for (int i = 0; i < n; i++) begin
            ta = av[2*i +: 2];
            tb = bv[2*i +: 2];
            if (ta == 2'b11 || tb == 2'b11) begin
                if (!ee) begin
                    ee = 1'b1;
                    ie = 4'(i);
                end
                if (stop) begin
                    le = i + 2;
                    break;
                end
            end else begin
                s = tval(ta) + tval(tb);
                if (s > 1)  s = s - 3;
                if (s < -1) s = s + 3;
                ce[2*i +: 2] = enc(s);
            end
        end
    endtask

    function automatic logic [17:0] rand_word(input int n);
        logic [17:0] w;
        int r;
        w = '0;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) w[2*i +: 2] = 2'b11;
            else        w[2*i +: 2] = enc($urandom_range(0, 2) - 1);
        end
        return w;
    endfunction

    // ---------------- driver ----------------
    // Launches one operation; with poke set, start stays high with fresh
    // operands through RUN and DONE to prove they are ignored.
    task automatic run_op(input int d, input logic [17:0] av, input logic [17:0] bv, input bit poke,
                          output logic [17:0] cr, output logic er, output logic [3:0] ir,
                          output logic [17:0] c_idle, output int lat);
        bit got;
        @(negedge clk);
        a_v[d] = av; b_v[d] = bv; start_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy_v[d] !== 1'b1 || done_v[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_busy dut%0d: busy=%b done=%b, required busy=1 done=0", d, busy_v[d], done_v[d]);
        end
        if (poke) begin
            a_v[d] = 18'($urandom); b_v[d] = 18'($urandom);
        end else begin
            start_v[d] = 1'b0;
        end
        got = 1'b0; lat = -1;
        cr = '0; er = 1'b0; ir = '0; c_idle = '0;
        for (int cnt = 1; cnt <= 40 && !got; cnt++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[d] === 1'b1) begin
                got = 1'b1;
                lat = cnt + 1;
            end else if (poke) begin
                a_v[d] = 18'($urandom); b_v[d] = 18'($urandom);
            end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout dut%0d: no done within 40 cycles, required done", d);
        end else begin
            cr = c_v[d]; er = err_v[d]; ir = idx_v[d];
            n_cmp++;
            if (busy_v[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_in_done dut%0d: busy=%b, required 1", d, busy_v[d]);
            end
            @(posedge clk);
            @(negedge clk);
            start_v[d] = 1'b0;
            c_idle = c_v[d];
            n_cmp++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse dut%0d: busy=%b done=%b after DONE, required 0 0", d, busy_v[d], done_v[d]);
            end
        end
        start_v[d] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || c_v[d] !== 18'd0 ||
                err_v[d] !== 1'b0 || idx_v[d] !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b c=%h err=%b idx=%0d, required all 0",
                         d, busy_v[d], done_v[d], c_v[d], err_v[d], idx_v[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed(input string nm, input int d, input logic [17:0] av, input logic [17:0] bv,
                                 input logic [17:0] ce, input logic ee, input logic [3:0] ie, input int le);
        logic [17:0] cr, ci;
        logic er;
        logic [3:0] ir;
        int lat;
        run_op(d, av, bv, 1'b0, cr, er, ir, ci, lat);
        n_cmp++;
        if (cr !== ce || er !== ee || ir !== ie) begin
            n_fail++;
            $display("FAIL %s_result: c=%h err=%b idx=%0d, required c=%h err=%b idx=%0d", nm, cr, er, ir, ce, ee, ie);
        end
        n_cmp++;
        if (lat !== le) begin
            n_fail++;
            $display("FAIL %s_latency: %0d cycles, required %0d", nm, lat, le);
        end
        n_cmp++;
        if (ci !== ce) begin
            n_fail++;
            $display("FAIL %s_hold: c=%h in IDLE, required %h", nm, ci, ce);
        end
    endtask

    task automatic test_busy_protect();
        logic [17:0] cr, ci, ce, av, bv;
        logic er, ee;
        logic [3:0] ir, ie;
        int lat, le;
        for (int d = 0; d < 3; d++) begin
            av = rand_word(nt[d]); bv = rand_word(nt[d]);
            model(nt[d], stp[d], av, bv, ce, ee, ie, le);
            run_op(d, av, bv, 1'b1, cr, er, ir, ci, lat);
            n_cmp++;
            if (cr !== ce || er !== ee || ir !== ie || ci !== ce || lat !== le) begin
                n_fail++;
                $display("FAIL busy_protect dut%0d: c=%h/%h err=%b idx=%0d lat=%0d, required c=%h err=%b idx=%0d lat=%0d",
                         d, cr, ci, er, ir, lat, ce, ee, ie, le);
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                n_cmp++;
                if (done_v[d] !== 1'b0 || busy_v[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL extra_done dut%0d: done=%b busy=%b after op, required 0 0", d, done_v[d], busy_v[d]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [17:0] cr, ci, ce, av, bv;
        logic er, ee;
        logic [3:0] ir, ie;
        int lat, le;
        @(negedge clk);
        a_v[2] = rand_word(9); b_v[2] = 18'h2aaaa; start_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[2] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0 || c_v[2] !== 18'd0 || err_v[2] !== 1'b0 || idx_v[2] !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: busy=%b done=%b c=%h err=%b idx=%0d, required all 0",
                     busy_v[2], done_v[2], c_v[2], err_v[2], idx_v[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: busy=%b done=%b, required 0 0", busy_v[2], done_v[2]);
        end
        av = rand_word(9); bv = rand_word(9);
        model(9, 1'b0, av, bv, ce, ee, ie, le);
        run_op(2, av, bv, 1'b0, cr, er, ir, ci, lat);
        n_cmp++;
        if (cr !== ce || er !== ee || ir !== ie || lat !== le) begin
            n_fail++;
            $display("FAIL mid_reset_next: c=%h err=%b idx=%0d lat=%0d, required c=%h err=%b idx=%0d lat=%0d",
                     cr, er, ir, lat, ce, ee, ie, le);
        end
    endtask

    task automatic test_random();
        logic [17:0] cr, ci, ce, av, bv;
        logic er, ee;
        logic [3:0] ir, ie;
        int lat, le, d;
        for (int t = 0; t < 30; t++) begin
            d = $urandom_range(0, 2);
            av = rand_word(nt[d]); bv = rand_word(nt[d]);
            model(nt[d], stp[d], av, bv, ce, ee, ie, le);
            run_op(d, av, bv, 1'b0, cr, er, ir, ci, lat);
            n_cmp++;
            if (cr !== ce || er !== ee || ir !== ie || ci !== ce || lat !== le) begin
                n_fail++;
                $display("FAIL random_op t%0d dut%0d a=%h b=%h: c=%h err=%b idx=%0d lat=%0d, required c=%h err=%b idx=%0d lat=%0d",
                         t, d, av, bv, cr, er, ir, lat, ce, ee, ie, le);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] ce;
        int pulses, cyc, last;
        ce = '0;
        for (int i = 0; i < 9; i++) ce[2*i +: 2] = 2'b01;
        @(negedge clk);
        a_v[2] = 18'h2aaaa; b_v[2] = 18'h2aaaa; start_v[2] = 1'b1;
        pulses = 0; cyc = 0; last = 0;
        for (int k = 0; k < 200 && pulses < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done_v[2] === 1'b1) begin
                n_cmp++;
                if (c_v[2] !== ce || err_v[2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result pulse%0d: c=%h err=%b, required c=%h err=0", pulses, c_v[2], err_v[2], ce);
                end
                n_cmp++;
                if (cyc - last !== ((pulses == 0) ? 10 : 11)) begin
                    n_fail++;
                    $display("FAIL b2b_interval pulse%0d: %0d cycles, required %0d", pulses, cyc - last, (pulses == 0) ? 10 : 11);
                end
                last = cyc;
                pulses++;
            end
        end
        start_v[2] = 1'b0;
        n_cmp++;
        if (pulses != 4) begin
            n_fail++;
            $display("FAIL b2b_count: %0d done pulses, required 4", pulses);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_v[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b, required 0", busy_v[2]);
        end
    endtask

    initial begin
        test_reset();
        test_directed("basic", 0, 18'b10_00_01, 18'b10_10_01, 18'b01_10_10, 1'b0, 4'd0, 4);
        test_directed("err_noabort", 0, 18'b00_11_10, 18'b01_00_10, 18'b01_00_01, 1'b1, 4'd1, 4);
        test_directed("err_abort", 1, 18'b00_11_10, 18'b01_00_10, 18'b00_00_01, 1'b1, 4'd1, 3);
        test_directed("abort_trit0", 1, 18'b10_10_11, 18'b10_10_00, 18'b00_00_00, 1'b1, 4'd0, 2);
        test_directed("err_last", 2, 18'h3aaaa, 18'h00000, 18'h2aaaa & 18'h0ffff, 1'b1, 4'd8, 10);
        test_busy_protect();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
